// File: rtl/alarm_trigger.sv
// Alarm/chime request generator for the bell stage: matches time-of-day against the
// programmed alarm and hourly chime, and manages snooze, stop and the ring window.
module alarm_trigger #(
    parameter int BELL_LEN   = 5,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       alarm_en,
    input  logic       chime_en,
    input  logic       snooze,
    input  logic       stop,
    output logic       sig_ring,
    output logic       sig_step,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       snoozing
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, SNOOZE} state_t;

    localparam int          WIN_W       = $clog2(BELL_LEN + 1);
    localparam int          SNZ_W       = $clog2(MAX_SNOOZE + 1);
    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60 - 1);

    state_t             state_q, state_d;
    logic               src_alarm_q, src_alarm_d;
    logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [11:0]        sec_cnt_q, sec_cnt_d;
    logic               step_q;
    logic [4:0]         alarm_hour_q;
    logic [5:0]         alarm_min_q;

    logic match_tick, match_a, match_c, snooze_ok, alarm_owned;

    // A tick with cur_sec==0 occurs once per minute, so matches cannot repeat within it.
    assign match_tick  = tick_1hz && (cur_sec == 6'd0);
    assign match_a     = match_tick && alarm_en && (cur_hour == alarm_hour_q)
                         && (cur_min == alarm_min_q);
    assign match_c     = match_tick && chime_en && (cur_min == 6'd0);
    assign alarm_owned = (state_q == REQ && src_alarm_q) || state_q == ACTIVE
                         || state_q == SNOOZE;
    assign snooze_ok   = snooze && (snz_cnt_q < SNZ_W'(MAX_SNOOZE))
                         && ((state_q == REQ && src_alarm_q) || state_q == ACTIVE);

    always_comb begin
        state_d     = state_q;
        src_alarm_d = src_alarm_q;
        snz_cnt_d   = snz_cnt_q;
        win_cnt_d   = win_cnt_q;
        sec_cnt_d   = sec_cnt_q;
        if (stop) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
        end else if (!alarm_en && alarm_owned) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
        end else if (snooze_ok) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + 1'b1;
            sec_cnt_d = SNOOZE_LOAD;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match_a) begin
                        state_d     = REQ;
                        src_alarm_d = 1'b1;
                        snz_cnt_d   = '0;
                    end else if (match_c) begin
                        state_d     = REQ;
                        src_alarm_d = 1'b0;
                    end
                end
                REQ: begin
                    // Leave only after the bell stage has seen ring high during a step pulse.
                    if (step_q) begin
                        state_d   = src_alarm_q ? ACTIVE : IDLE;
                        win_cnt_d = '0;
                    end
                end
                ACTIVE: begin
                    if (tick_1hz) begin
                        if (win_cnt_q == WIN_W'(BELL_LEN - 1)) state_d = IDLE;
                        else win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (tick_1hz) begin
                        if (sec_cnt_q == 12'd0) begin
                            state_d     = REQ;
                            src_alarm_d = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_alarm_q  <= 1'b0;
            snz_cnt_q    <= '0;
            win_cnt_q    <= '0;
            sec_cnt_q    <= '0;
            step_q       <= 1'b0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_alarm_q <= src_alarm_d;
            snz_cnt_q   <= snz_cnt_d;
            win_cnt_q   <= win_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            step_q      <= tick_1hz;
            if (set_en && set_hour <= 5'd23 && set_min <= 6'd59) begin
                alarm_hour_q <= set_hour;
                alarm_min_q  <= set_min;
            end
        end
    end

    assign sig_ring   = (state_q == REQ);
    assign sig_step   = step_q;
    assign snoozing   = (state_q == SNOOZE);
    assign alarm_hour = alarm_hour_q;
    assign alarm_min  = alarm_min_q;

endmodule
